// File: rtl/operand_collector_pkg.sv
// Shared types for the operand collector: ALU source-select encodings and collector states.
package operand_collector_pkg;

    typedef enum logic [1:0] {
        SEL_RR  = 2'd0,
        SEL_RI  = 2'd1,
        SEL_SHV = 2'd2,
        SEL_SHI = 2'd3
    } operand_sel_t;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_COLLECT = 2'd1,
        ST_READY   = 2'd2
    } oc_state_t;

endpackage

// File: rtl/operand_collector_fwd_resolve.sv
// Priority matcher over the forwarding channels for one source register.
// Channel 0 is the youngest producer and wins; register 0 always hits with value zero.
module fwd_resolve #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int FWD_CH = 2
) (
    input  logic [REG_W-1:0]         addr,
    input  logic [FWD_CH-1:0]        fwd_valid,
    input  logic [FWD_CH-1:0]        fwd_pending,
    input  logic [FWD_CH*REG_W-1:0]  fwd_addr,
    input  logic [FWD_CH*DATA_W-1:0] fwd_data,
    output logic                     hit,
    output logic                     waiting,
    output logic [DATA_W-1:0]        data
);

    always_comb begin
        hit     = 1'b0;
        waiting = 1'b0;
        data    = '0;
        if (addr == '0) begin
            hit = 1'b1;
        end else begin
            // Walk oldest to youngest so the lowest matching channel is the last one written.
            for (int c = FWD_CH - 1; c >= 0; c--) begin
                if ((fwd_addr[c*REG_W +: REG_W] == addr) && (fwd_valid[c] || fwd_pending[c])) begin
                    hit     = 1'b1;
                    waiting = fwd_pending[c];
                    data    = fwd_data[c*DATA_W +: DATA_W];
                end
            end
        end
    end

endmodule

// File: rtl/operand_collector.sv
// EX-stage operand collector: resolves rs/rt through forwarding, waits out load-use hazards,
// and holds the mapped ALU operands behind a valid/ready handshake.
module operand_collector
    import operand_collector_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int FWD_CH = 2,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               in_sel,
    input  logic [REG_W-1:0]         in_rs_addr,
    input  logic [REG_W-1:0]         in_rt_addr,
    input  logic [DATA_W-1:0]        in_rs_data,
    input  logic [DATA_W-1:0]        in_rt_data,
    input  logic [DATA_W-1:0]        in_imme,
    input  logic [FWD_CH-1:0]        fwd_valid,
    input  logic [FWD_CH-1:0]        fwd_pending,
    input  logic [FWD_CH*REG_W-1:0]  fwd_addr,
    input  logic [FWD_CH*DATA_W-1:0] fwd_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        source_a,
    output logic [DATA_W-1:0]        source_b,
    output logic [DATA_W-1:0]        source_data,
    output logic [CNT_W-1:0]         wait_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    oc_state_t           state_q, state_d;
    operand_sel_t        sel_q, sel_d;
    logic [REG_W-1:0]    rs_addr_q, rs_addr_d, rt_addr_q, rt_addr_d;
    logic [DATA_W-1:0]   rs_val_q, rs_val_d, rt_val_q, rt_val_d;
    logic                rs_done_q, rs_done_d, rt_done_q, rt_done_d;
    logic [DATA_W-1:0]   imme_q, imme_d;
    logic [DATA_W-1:0]   src_a_q, src_a_d, src_b_q, src_b_d, src_data_q, src_data_d;
    logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;

    logic                accept;
    logic                collecting;
    operand_sel_t        cur_sel;
    logic [REG_W-1:0]    cur_rs_addr, cur_rt_addr;
    logic [DATA_W-1:0]   cur_rs_reg, cur_rt_reg, cur_imme;
    logic                cur_rs_done, cur_rt_done;
    logic                rs_hit, rs_waiting, rt_hit, rt_waiting;
    logic [DATA_W-1:0]   rs_fwd_data, rt_fwd_data;
    logic                rs_ok, rt_ok;
    logic [DATA_W-1:0]   rs_now, rt_now;
    logic [DATA_W-1:0]   map_a, map_b;

    assign in_ready   = (state_q == ST_EMPTY) || ((state_q == ST_READY) && out_ready);
    assign accept     = in_valid && in_ready;
    assign collecting = accept || (state_q == ST_COLLECT);

    // On an accept the fresh ID/EX fields are resolved directly; otherwise the held copies are.
    assign cur_sel     = accept ? operand_sel_t'(in_sel) : sel_q;
    assign cur_rs_addr = accept ? in_rs_addr : rs_addr_q;
    assign cur_rt_addr = accept ? in_rt_addr : rt_addr_q;
    assign cur_rs_reg  = accept ? in_rs_data : rs_val_q;
    assign cur_rt_reg  = accept ? in_rt_data : rt_val_q;
    assign cur_imme    = accept ? in_imme    : imme_q;
    assign cur_rs_done = accept ? 1'b0 : rs_done_q;
    assign cur_rt_done = accept ? 1'b0 : rt_done_q;

    fwd_resolve #(.DATA_W(DATA_W), .REG_W(REG_W), .FWD_CH(FWD_CH)) u_rs_resolve (
        .addr        (cur_rs_addr),
        .fwd_valid   (fwd_valid),
        .fwd_pending (fwd_pending),
        .fwd_addr    (fwd_addr),
        .fwd_data    (fwd_data),
        .hit         (rs_hit),
        .waiting     (rs_waiting),
        .data        (rs_fwd_data)
    );

    fwd_resolve #(.DATA_W(DATA_W), .REG_W(REG_W), .FWD_CH(FWD_CH)) u_rt_resolve (
        .addr        (cur_rt_addr),
        .fwd_valid   (fwd_valid),
        .fwd_pending (fwd_pending),
        .fwd_addr    (fwd_addr),
        .fwd_data    (fwd_data),
        .hit         (rt_hit),
        .waiting     (rt_waiting),
        .data        (rt_fwd_data)
    );

    // A still-waiting operand keeps its register-file value so a later miss can fall back to it.
    assign rs_ok  = cur_rs_done || !rs_waiting;
    assign rt_ok  = cur_rt_done || !rt_waiting;
    assign rs_now = cur_rs_done ? rs_val_q : ((rs_hit && !rs_waiting) ? rs_fwd_data : cur_rs_reg);
    assign rt_now = cur_rt_done ? rt_val_q : ((rt_hit && !rt_waiting) ? rt_fwd_data : cur_rt_reg);

    always_comb begin
        map_a = rs_now;
        map_b = rt_now;
        case (cur_sel)
            SEL_RR:  begin map_a = rs_now; map_b = rt_now;   end
            SEL_RI:  begin map_a = rs_now; map_b = cur_imme; end
            SEL_SHV: begin map_a = rt_now; map_b = rs_now;   end
            SEL_SHI: begin map_a = rt_now; map_b = cur_imme; end
            default: begin map_a = rs_now; map_b = rt_now;   end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        rs_addr_d  = rs_addr_q;
        rt_addr_d  = rt_addr_q;
        rs_val_d   = rs_val_q;
        rt_val_d   = rt_val_q;
        rs_done_d  = rs_done_q;
        rt_done_d  = rt_done_q;
        imme_d     = imme_q;
        src_a_d    = src_a_q;
        src_b_d    = src_b_q;
        src_data_d = src_data_q;
        wait_cnt_d = wait_cnt_q;

        if ((state_q == ST_COLLECT) && (wait_cnt_q != '1)) begin
            wait_cnt_d = wait_cnt_q + CNT_ONE;
        end

        if (collecting) begin
            sel_d     = cur_sel;
            rs_addr_d = cur_rs_addr;
            rt_addr_d = cur_rt_addr;
            rs_val_d  = rs_now;
            rt_val_d  = rt_now;
            rs_done_d = rs_ok;
            rt_done_d = rt_ok;
            imme_d    = cur_imme;
        end

        if (flush) begin
            state_d = ST_EMPTY;
        end else if (accept) begin
            state_d = (rs_ok && rt_ok) ? ST_READY : ST_COLLECT;
        end else begin
            case (state_q)
                ST_COLLECT: if (rs_ok && rt_ok) state_d = ST_READY;
                ST_READY:   if (out_ready)      state_d = ST_EMPTY;
                default:    state_d = state_q;
            endcase
        end

        // Output operands change only when a new instruction becomes ready, so they hold under stall.
        if (!flush && collecting && rs_ok && rt_ok) begin
            src_a_d    = map_a;
            src_b_d    = map_b;
            src_data_d = rt_now;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_EMPTY;
            sel_q      <= SEL_RR;
            rs_addr_q  <= '0;
            rt_addr_q  <= '0;
            rs_val_q   <= '0;
            rt_val_q   <= '0;
            rs_done_q  <= 1'b0;
            rt_done_q  <= 1'b0;
            imme_q     <= '0;
            src_a_q    <= '0;
            src_b_q    <= '0;
            src_data_q <= '0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            rs_addr_q  <= rs_addr_d;
            rt_addr_q  <= rt_addr_d;
            rs_val_q   <= rs_val_d;
            rt_val_q   <= rt_val_d;
            rs_done_q  <= rs_done_d;
            rt_done_q  <= rt_done_d;
            imme_q     <= imme_d;
            src_a_q    <= src_a_d;
            src_b_q    <= src_b_d;
            src_data_q <= src_data_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign out_valid   = (state_q == ST_READY);
    assign source_a    = src_a_q;
    assign source_b    = src_b_q;
    assign source_data = src_data_q;
    assign wait_cnt    = wait_cnt_q;

endmodule

// File: tb/tb_operand_collector.sv
// Bench for operand_collector: directed hazard scenarios followed by random traffic,
// all checked against an instruction-level model of the collector.
module tb_operand_collector;
    import operand_collector_pkg::*;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int FWD_CH = 2;
    localparam int CNT_W  = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic                     clk = 1'b0;
    logic                     resetn;
    logic                     flush;
    logic                     in_valid;
    logic                     in_ready;
    logic [1:0]               in_sel;
    logic [REG_W-1:0]         in_rs_addr, in_rt_addr;
    logic [DATA_W-1:0]        in_rs_data, in_rt_data, in_imme;
    logic [FWD_CH-1:0]        fwd_valid, fwd_pending;
    logic [FWD_CH*REG_W-1:0]  fwd_addr;
    logic [FWD_CH*DATA_W-1:0] fwd_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_W-1:0]        source_a, source_b, source_data;
    logic [CNT_W-1:0]         wait_cnt;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: one held instruction, plus the presented operands.
    bit          m_held, m_ov;
    bit          m_rs_ok, m_rt_ok;
    logic [4:0]  m_rs_a, m_rt_a;
    logic [31:0] m_rs_v, m_rt_v, m_imme;
    logic [1:0]  m_sel;
    logic [31:0] m_a, m_b, m_d;
    int          m_wait;

    operand_collector #(.DATA_W(DATA_W), .REG_W(REG_W), .FWD_CH(FWD_CH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_sel      (in_sel),
        .in_rs_addr  (in_rs_addr),
        .in_rt_addr  (in_rt_addr),
        .in_rs_data  (in_rs_data),
        .in_rt_data  (in_rt_data),
        .in_imme     (in_imme),
        .fwd_valid   (fwd_valid),
        .fwd_pending (fwd_pending),
        .fwd_addr    (fwd_addr),
        .fwd_data    (fwd_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .source_a    (source_a),
        .source_b    (source_b),
        .source_data (source_data),
        .wait_cnt    (wait_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input bit v, input logic [1:0] sel,
                                 input logic [4:0] rsa, input logic [31:0] rsd,
                                 input logic [4:0] rta, input logic [31:0] rtd,
                                 input logic [31:0] imm);
        in_valid   = v;
        in_sel     = sel;
        in_rs_addr = rsa;
        in_rs_data = rsd;
        in_rt_addr = rta;
        in_rt_data = rtd;
        in_imme    = imm;
    endtask

    task automatic setFwd(input int c, input bit v, input bit p, input logic [4:0] a, input logic [31:0] d);
        fwd_valid[c]                 = v;
        fwd_pending[c]               = p;
        fwd_addr[c*REG_W +: REG_W]   = a;
        fwd_data[c*DATA_W +: DATA_W] = d;
    endtask

    task automatic clearFwd();
        fwd_valid   = '0;
        fwd_pending = '0;
        fwd_addr    = '0;
        fwd_data    = '0;
    endtask

    task automatic modelReset();
        m_held = 0; m_ov = 0; m_rs_ok = 0; m_rt_ok = 0;
        m_a = 0; m_b = 0; m_d = 0; m_wait = 0;
    endtask

    // Register 0 reads zero; otherwise the youngest matching producer decides, else the register file.
    function automatic void refResolve(input logic [4:0] a, input logic [31:0] regv,
                                       output bit ok, output logic [31:0] v);
        ok = 1;
        v  = regv;
        if (a == 5'd0) begin
            v = 32'd0;
            return;
        end
        for (int c = 0; c < FWD_CH; c++) begin
            if (fwd_addr[c*REG_W +: REG_W] == a && (fwd_valid[c] || fwd_pending[c])) begin
                if (fwd_pending[c]) ok = 0;
                else v = fwd_data[c*DATA_W +: DATA_W];
                return;
            end
        end
    endfunction

    task automatic modelResolveHeld();
        bit ok;
        logic [31:0] v;
        if (!m_rs_ok) begin
            refResolve(m_rs_a, m_rs_v, ok, v);
            if (ok) begin m_rs_ok = 1; m_rs_v = v; end
        end
        if (!m_rt_ok) begin
            refResolve(m_rt_a, m_rt_v, ok, v);
            if (ok) begin m_rt_ok = 1; m_rt_v = v; end
        end
        if (m_rs_ok && m_rt_ok) begin
            m_held = 0;
            m_ov   = 1;
            m_d    = m_rt_v;
            case (m_sel)
                2'd0: begin m_a = m_rs_v; m_b = m_rt_v; end
                2'd1: begin m_a = m_rs_v; m_b = m_imme; end
                2'd2: begin m_a = m_rt_v; m_b = m_rs_v; end
                default: begin m_a = m_rt_v; m_b = m_imme; end
            endcase
        end
    endtask

    // One clock: compare outputs mid-cycle, advance the model, end 1 time unit after the edge.
    task automatic tick();
        bit exp_rdy, acc;
        @(negedge clk);
        exp_rdy = (!m_held && !m_ov) || (m_ov && out_ready);
        checkOutput("in_ready", in_ready, exp_rdy);
        checkOutput("out_valid", out_valid, m_ov);
        checkOutput("wait_cnt", wait_cnt, m_wait);
        if (m_ov) begin
            checkOutput("source_a", source_a, m_a);
            checkOutput("source_b", source_b, m_b);
            checkOutput("source_data", source_data, m_d);
        end
        acc = in_valid && exp_rdy;
        if (m_held && m_wait < CNT_MAX) m_wait++;
        if (flush) begin
            m_held = 0;
            m_ov   = 0;
        end else if (acc) begin
            m_sel = in_sel; m_imme = in_imme;
            m_rs_a = in_rs_addr; m_rs_v = in_rs_data; m_rs_ok = 0;
            m_rt_a = in_rt_addr; m_rt_v = in_rt_data; m_rt_ok = 0;
            m_held = 1; m_ov = 0;
            modelResolveHeld();
        end else if (m_held) begin
            modelResolveHeld();
        end else if (m_ov && out_ready) begin
            m_ov = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_out_valid"}, out_valid, 1'b0);
        checkOutput({tag, "_in_ready"}, in_ready, 1'b1);
        checkOutput({tag, "_a"}, source_a, 32'd0);
        checkOutput({tag, "_b"}, source_b, 32'd0);
        checkOutput({tag, "_data"}, source_data, 32'd0);
        checkOutput({tag, "_wait"}, wait_cnt, 4'd0);
    endtask

    initial begin
        resetn = 1'b0; flush = 1'b0; out_ready = 1'b1;
        applyStimulus(0, SEL_RR, 0, 0, 0, 0, 0);
        clearFwd();
        modelReset();
        #3;
        checkResetState("reset");
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] no-hazard accept");
        applyStimulus(1, SEL_RR, 5'd3, 32'h11, 5'd4, 32'h22, 32'h0);
        tick();
        checkOutput("nohaz_valid", out_valid, 1'b1);
        checkOutput("nohaz_a", source_a, 32'h11);
        checkOutput("nohaz_b", source_b, 32'h22);
        checkOutput("nohaz_data", source_data, 32'h22);

        $display("[TB] forwarding priority");
        setFwd(0, 1, 0, 5'd3, 32'hAA);
        setFwd(1, 1, 0, 5'd3, 32'hBB);
        applyStimulus(1, SEL_RR, 5'd3, 32'h11, 5'd4, 32'h22, 32'h0);
        tick();
        checkOutput("prio_a", source_a, 32'hAA);
        setFwd(0, 1, 0, 5'd0, 32'h77);
        applyStimulus(1, SEL_RR, 5'd0, 32'h99, 5'd4, 32'h22, 32'h0);
        tick();
        checkOutput("prio_zero_a", source_a, 32'h0);

        $display("[TB] load-use stall");
        clearFwd();
        setFwd(1, 0, 1, 5'd4, 32'hDEAD);
        applyStimulus(1, SEL_RR, 5'd1, 32'h1, 5'd4, 32'h9, 32'h0);
        tick();
        applyStimulus(0, SEL_RR, 0, 0, 0, 0, 0);
        tick();
        tick();
        setFwd(1, 1, 0, 5'd4, 32'h5555);
        tick();
        checkOutput("lu_valid", out_valid, 1'b1);
        checkOutput("lu_b", source_b, 32'h5555);
        checkOutput("lu_wait", wait_cnt, 4'd3);

        $display("[TB] modes under back-pressure");
        clearFwd();
        applyStimulus(1, SEL_SHV, 5'd1, 32'h4, 5'd2, 32'h80, 32'h0);
        tick();
        out_ready = 1'b0;
        applyStimulus(1, SEL_SHI, 5'd1, 32'h4, 5'd2, 32'h80, 32'h2);
        for (int i = 0; i < 2; i++) begin
            tick();
            checkOutput("bp_a", source_a, 32'h80);
            checkOutput("bp_b", source_b, 32'h4);
            checkOutput("bp_in_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        tick();
        checkOutput("shi_a", source_a, 32'h80);
        checkOutput("shi_b", source_b, 32'h2);

        $display("[TB] flush in COLLECT");
        setFwd(0, 0, 1, 5'd5, 32'h0);
        applyStimulus(1, SEL_RI, 5'd5, 32'h5, 5'd0, 32'h0, 32'h3);
        tick();
        applyStimulus(0, SEL_RR, 0, 0, 0, 0, 0);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checkOutput("flush_valid", out_valid, 1'b0);
        checkOutput("flush_in_ready", in_ready, 1'b1);
        tick();

        $display("[TB] reset while READY");
        clearFwd();
        applyStimulus(1, SEL_RR, 5'd6, 32'h66, 5'd7, 32'h77, 32'h0);
        out_ready = 1'b0;
        tick();
        applyStimulus(0, SEL_RR, 0, 0, 0, 0, 0);
        resetn = 1'b0;
        #1;
        modelReset();
        checkResetState("midreset");
        @(negedge clk);
        resetn = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] wait counter saturation");
        setFwd(0, 0, 1, 5'd6, 32'h0);
        applyStimulus(1, SEL_RR, 5'd6, 32'h66, 5'd0, 32'h0, 32'h0);
        tick();
        applyStimulus(0, SEL_RR, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) tick();
        checkOutput("sat_wait", wait_cnt, 4'hF);
        clearFwd();
        tick();
        checkOutput("sat_release_a", source_a, 32'h66);
        tick();

        $display("[TB] random traffic");
        resetn = 1'b0;
        #1;
        modelReset();
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom % 3) != 0, 2'($urandom % 4),
                          5'($urandom_range(0, 7)), $urandom,
                          5'($urandom_range(0, 7)), $urandom, $urandom);
            for (int c = 0; c < FWD_CH; c++)
                setFwd(c, ($urandom % 2) == 0, ($urandom % 4) == 0, 5'($urandom_range(0, 7)), $urandom);
            out_ready = ($urandom % 4) != 0;
            flush     = ($urandom % 16) == 0;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
